seg7_mux_driver: RTL and testbench

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_mux_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_mux_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver. Each digit slot starts with anode-off guard cycles.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_mux_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]       val_q;
    logic [NUM_DIGITS-1:0]  dpm_q;
    logic [6:0]             seg_d;
    logic                   dp_d;
    logic [NUM_DIGITS-1:0]  an_d;

    logic [3:0]             sel_nib;
    logic                   sel_dp;
    logic                   sel_lz;
    logic [NUM_DIGITS-1:0]  sel_an;
    logic [NUM_DIGITS-1:0]  lead_zero;
    logic                   wrap;

    // Segment pattern {a,b,c,d,e,f,g}, active low.
    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

`ifdef SEG7_LZB_EN
    // Digit k>0 is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_hi;
        zero_hi   = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_hi      = zero_hi && (val_q[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_hi;
        end
    end
`else
    assign lead_zero = '0;
`endif

    // Pick the nibble, decimal point and anode for the current digit index.
    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_lz  = 1'b0;
        sel_an  = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_nib   = val_q[4*k +: 4];
                sel_dp    = dpm_q[k];
                sel_lz    = lead_zero[k];
                sel_an[k] = 1'b0;
            end
        end
    end

    assign wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        state_d = state_q;
        seg_d   = '1;
        dp_d    = 1'b1;
        an_d    = '1;

        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            ST_GUARD: if (cnt_q == CNT_W'(GUARD - 1)) state_d = ST_ON;
            ST_ON:    if (wrap) state_d = ST_GUARD;
            default:  state_d = ST_GUARD;
        endcase

        // Blank only darkens the outputs; slot timing keeps running.
        if (state_q == ST_ON && !blank) begin
            an_d  = sel_an;
            dp_d  = ~sel_dp;
            seg_d = sel_lz ? 7'b1111111 : seg_enc(sel_nib);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dpm_q   <= '0;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
            an      <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) begin
                val_q <= value;
                dpm_q <= dp_in;
            end
            seg <= seg_d;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver (4 digits, 8-cycle slots, 2 guard cycles).
`timescale 1ns/1ps
module tb_seg7_mux_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } out_t;

    out_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          pos = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;

    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value),
        .dp_in(dp_in), .blank(blank), .seg(seg), .dp(dp), .an(an));

    always #5 clk = ~clk;

    // Expected outputs registered at the edge that ends cycle `p` since reset.
    function automatic out_t model(input int p, input logic bl,
                                   input logic [15:0] v, input logic [3:0] d);
        out_t r;
        int   c;
        int   id;
        c = p % 8;
        id = (p / 8) % 4;
        r.seg = 7'b1111111;
        r.dp  = 1'b1;
        r.an  = 4'b1111;
        if (!bl && c >= 2) begin
            r.an  = ~(4'b0001 << id);
            r.dp  = ~d[id];
            r.seg = seg_tbl[v[4*id +: 4]];
`ifdef SEG7_LZB_EN
            if (id > 0 && (v >> (4 * id)) == 16'h0) r.seg = 7'b1111111;
`endif
        end
        return r;
    endfunction

    // One clock: drive inputs, push expectation, compare after the edge. Entered/left at negedge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic bl);
        out_t e;
        out_t got;
        load = ld; value = v; dp_in = d; blank = bl;
        sb.push_back(model(pos, bl, m_val, m_dp));
        @(posedge clk);
        if (ld) begin
            m_val = v;
            m_dp  = d;
        end
        pos++;
        #1;
        got = '{seg: seg, dp: dp, an: an};
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty at pos %0d", pos);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                n_errors++;
                $display("FAIL outputs pos=%0d: got seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
                         pos, got.seg, got.dp, got.an, e.seg, e.dp, e.an);
            end
        end
        n_checks++;
        if ($countones(~an) > 1) begin
            n_errors++;
            $display("FAIL an_onehot pos=%0d: got an=%b, expected at most one low bit", pos, an);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, value, dp_in, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg, dp, an} !== 12'hFFF) begin
            n_errors++;
            $display("FAIL reset_outputs: got seg=%b dp=%b an=%b, expected all ones", seg, dp, an);
        end
        reset_n = 1'b1;
        pos = 0; m_val = '0; m_dp = '0;
        idle(12);
    endtask

    task automatic test_count_pattern();
        while (pos % 8 != 7) idle(1);
        step(1'b1, 16'h1234, 4'b0000, 1'b0);
        idle(40);
    endtask

    task automatic test_lzb();
        step(1'b1, 16'h00A5, 4'b0000, 1'b0);
        idle(34);
    endtask

    task automatic test_blank();
        while (pos % 8 != 4) idle(1);
        for (int i = 0; i < 5; i++) step(1'b0, value, dp_in, 1'b1);
        idle(20);
    endtask

    task automatic test_load_on_wrap();
        while (pos % 8 != 7) idle(1);
        step(1'b1, 16'hFFFF, 4'b0010, 1'b0);
        idle(34);
    endtask

    task automatic test_reset_mid();
        while (!(pos % 8 == 5 && (pos / 8) % 4 == 2)) idle(1);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({seg, dp, an} !== 12'hFFF) begin
            n_errors++;
            $display("FAIL reset_mid_dark: got seg=%b dp=%b an=%b, expected all ones", seg, dp, an);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pos = 0; m_val = '0; m_dp = '0;
        sb.delete();
        step(1'b0, 16'h0000, 4'b0000, 1'b0);
        step(1'b0, 16'h0000, 4'b0000, 1'b0);
        step(1'b1, 16'h0007, 4'b0001, 1'b0);
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001 || dp !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_first_digit: got seg=%b dp=%b an=%b, expected seg=0000001 dp=1 an=1110",
                     seg, dp, an);
        end
        idle(20);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count_pattern();
        test_lzb();
        test_blank();
        test_load_on_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
